freq_gate_sequencer: RTL and testbench

Measurement sequencer for the frequency meter. On a start request it waits a fixed settle interval, opens a counting gate of fixed length, counts rising edges of the measured signal inside the gate, and presents the count through a valid/ready handshake. It sits between the host/control logic and the edge-counting datapath, and replaces free-running, self-holding delay generators with a single restartable, abortable sequence.

---
 rtl/freq_meter_pkg.sv | 22 ++
 rtl/gate_interval_timer.sv | 27 ++
 rtl/freq_gate_sequencer.sv | 158 +++++++++++++++
 tb/tb_freq_gate_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and default timing constants for the frequency meter blocks.
// Cycle defaults assume a 50 MHz system clock.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    GATE,
    DONE
  } meter_state_t;

  localparam int unsigned SETTLE_CYCLES_DEF = 5000000;
  localparam int unsigned GATE_CYCLES_DEF   = 50000000;

  function automatic int unsigned max_u(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gate_interval_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// A load of N-1 gives exactly N cycles until done is seen by the consumer.
module gate_interval_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count;

  assign done = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (!done) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/freq_gate_sequencer.sv
// Settle/gate measurement sequencer: counts synchronized sigIn rising edges
// inside a fixed gate and hands the count out over valid/ready.
module freq_gate_sequencer
  import freq_meter_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned GATE_CYCLES   = GATE_CYCLES_DEF,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                 sysClk,
  input  logic                 sysRst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 sigIn,
  output logic                 busy,
  output logic                 gateOpen,
  output logic                 resultValid,
  input  logic                 resultReady,
  output logic [CNT_WIDTH-1:0] resultCount,
  output logic                 overflow
);

  localparam int unsigned TW =
    $clog2(max_u(SETTLE_CYCLES, GATE_CYCLES) + 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] GATE_LOAD   = TW'(GATE_CYCLES - 1);

  meter_state_t state, state_next;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;

  logic cnt_clr;
  logic latch;

  logic sync1, sync2, hist;
  logic strobe;

  logic [CNT_WIDTH-1:0] edge_cnt, cnt_next;
  logic                 ovf_run, ovf_next;

  gate_interval_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk     (sysClk),
    .rst     (sysRst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .done    (tmr_done)
  );

  assign busy        = (state != IDLE);
  assign gateOpen    = (state == GATE);
  assign resultValid = (state == DONE);

  always_ff @(posedge sysClk or posedge sysRst) begin
    if (sysRst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= sigIn;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign strobe = sync2 & ~hist;

  always_ff @(posedge sysClk or posedge sysRst) begin
    if (sysRst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // abort outranks every other exit condition in every busy state
  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    cnt_clr    = 1'b0;
    latch      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_next = SETTLE;
          tmr_load   = 1'b1;
          tmr_val    = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_next = IDLE;
          cnt_clr    = 1'b1;
        end else if (tmr_done) begin
          state_next = GATE;
          tmr_load   = 1'b1;
          tmr_val    = GATE_LOAD;
          cnt_clr    = 1'b1;
        end
      end
      GATE: begin
        if (abort) begin
          state_next = IDLE;
          cnt_clr    = 1'b1;
        end else if (tmr_done) begin
          state_next = DONE;
          latch      = 1'b1;
        end
      end
      DONE: begin
        if (abort) begin
          state_next = IDLE;
          cnt_clr    = 1'b1;
        end else if (resultReady) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_next = edge_cnt;
    ovf_next = ovf_run;
    if (cnt_clr) begin
      cnt_next = '0;
      ovf_next = 1'b0;
    end else if (gateOpen && strobe) begin
      if (&edge_cnt) begin
        ovf_next = 1'b1;
      end else begin
        cnt_next = edge_cnt + 1'b1;
      end
    end
  end

  // latch uses the next value so a strobe on the last gate cycle is kept
  always_ff @(posedge sysClk or posedge sysRst) begin
    if (sysRst) begin
      edge_cnt    <= '0;
      ovf_run     <= 1'b0;
      resultCount <= '0;
      overflow    <= 1'b0;
    end else begin
      edge_cnt <= cnt_next;
      ovf_run  <= ovf_next;
      if (latch) begin
        resultCount <= cnt_next;
        overflow    <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_freq_gate_sequencer.sv
// Directed bench for freq_gate_sequencer: main instance (4/20/8) plus a
// 3-bit saturation instance with a longer gate to fit ten edges.
module tb_freq_gate_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       sig = 1'b0;
  logic       ready = 1'b0;
  logic       busy, gate, valid, ovf;
  logic [7:0] rc;

  logic       start_s = 1'b0;
  logic       ready_s = 1'b0;
  logic       busy_s, gate_s, valid_s, ovf_s;
  logic [2:0] rc_s;

  int n_checks = 0;
  int n_fail   = 0;
  int gate_len = 0;
  int valid_cnt = 0;

  always #5 clk = ~clk;

  freq_gate_sequencer #(
    .SETTLE_CYCLES(4),
    .GATE_CYCLES  (20),
    .CNT_WIDTH    (8)
  ) dut (
    .sysClk     (clk),
    .sysRst     (rst),
    .start      (start),
    .abort      (abort),
    .sigIn      (sig),
    .busy       (busy),
    .gateOpen   (gate),
    .resultValid(valid),
    .resultReady(ready),
    .resultCount(rc),
    .overflow   (ovf)
  );

  freq_gate_sequencer #(
    .SETTLE_CYCLES(4),
    .GATE_CYCLES  (40),
    .CNT_WIDTH    (3)
  ) dut_sat (
    .sysClk     (clk),
    .sysRst     (rst),
    .start      (start_s),
    .abort      (1'b0),
    .sigIn      (sig),
    .busy       (busy_s),
    .gateOpen   (gate_s),
    .resultValid(valid_s),
    .resultReady(ready_s),
    .resultCount(rc_s),
    .overflow   (ovf_s)
  );

  always @(posedge clk) begin
    if (gate === 1'b1) gate_len++;
    if (valid === 1'b1) valid_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) begin
      sig = 1'b1;
      tick();
      sig = 1'b0;
      tick();
    end
  endtask

  task automatic wait_gate(output int k);
    k = 0;
    while (gate !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (valid !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({busy, gate, valid, ovf, rc} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_main: got %b/%b/%b/%b/%0d need 0", busy, gate, valid, ovf, rc);
    end
    n_checks++;
    if ({busy_s, gate_s, valid_s, ovf_s, rc_s} !== 7'h0) begin
      n_fail++;
      $display("FAIL reset_sat: got %b/%b/%b/%b/%0d need 0", busy_s, gate_s, valid_s, ovf_s, rc_s);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    int k;
    gate_len = 0;
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || gate !== 1'b0) begin
      n_fail++;
      $display("FAIL nom_busy: got busy=%b gate=%b need 1/0", busy, gate);
    end
    wait_gate(k);
    n_checks++;
    if (k != 4) begin
      n_fail++;
      $display("FAIL nom_settle: got %0d cycles need 4", k);
    end
    tick();
    tick();
    edges(7);
    wait_valid(k);
    n_checks++;
    if (valid !== 1'b1 || gate !== 1'b0) begin
      n_fail++;
      $display("FAIL nom_valid: got valid=%b gate=%b need 1/0", valid, gate);
    end
    n_checks++;
    if (gate_len != 20) begin
      n_fail++;
      $display("FAIL nom_gate_len: got %0d need 20", gate_len);
    end
    n_checks++;
    if (rc !== 8'd7 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL nom_count: got %0d ovf=%b need 7 ovf=0", rc, ovf);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL nom_accept: got busy=%b valid=%b need 0/0", busy, valid);
    end
  endtask

  task automatic test_backpressure();
    int k;
    int bad = 0;
    pulse_start();
    wait_gate(k);
    tick();
    tick();
    edges(4);
    wait_valid(k);
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      tick();
      n_checks++;
      if ({valid, rc} !== {1'b1, 8'd4}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got valid=%b count=%0d need 1/4", i, valid, rc);
      end
    end
    start = 1'b0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept: got busy=%b valid=%b need 0/0", busy, valid);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_no_restart: got %0d busy cycles need 0", bad);
    end
  endtask

  task automatic test_abort();
    int k;
    pulse_start();
    wait_gate(k);
    tick();
    tick();
    edges(4);
    valid_cnt = 0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || gate !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b gate=%b valid=%b need 0", busy, gate, valid);
    end
    for (int i = 0; i < 30; i++) tick();
    n_checks++;
    if (valid_cnt != 0) begin
      n_fail++;
      $display("FAIL abort_no_result: got %0d valid cycles need 0", valid_cnt);
    end
    pulse_start();
    wait_gate(k);
    tick();
    tick();
    edges(3);
    wait_valid(k);
    n_checks++;
    if (valid !== 1'b1 || rc !== 8'd3) begin
      n_fail++;
      $display("FAIL abort_rerun: got valid=%b count=%0d need 1/3", valid, rc);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic test_saturation();
    int k = 0;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    while (gate_s !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    tick();
    tick();
    edges(10);
    k = 0;
    while (valid_s !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    n_checks++;
    if (valid_s !== 1'b1 || rc_s !== 3'd7 || ovf_s !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_count: got valid=%b count=%0d ovf=%b need 1/7/1", valid_s, rc_s, ovf_s);
    end
    ready_s = 1'b1;
    tick();
    ready_s = 1'b0;
    n_checks++;
    if (busy_s !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_idle: got busy_s=%b busy=%b need 0/0", busy_s, busy);
    end
  endtask

  task automatic test_async_reset();
    int k;
    pulse_start();
    wait_gate(k);
    tick();
    tick();
    edges(2);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, gate, valid, ovf, rc} !== 12'h0) begin
      n_fail++;
      $display("FAIL arst_main: got %b/%b/%b/%b/%0d need 0", busy, gate, valid, ovf, rc);
    end
    n_checks++;
    if ({ovf_s, rc_s} !== 4'h0) begin
      n_fail++;
      $display("FAIL arst_sat: got ovf=%b count=%0d need 0", ovf_s, rc_s);
    end
    #2;
    rst = 1'b0;
    tick();
    pulse_start();
    wait_gate(k);
    tick();
    tick();
    edges(5);
    wait_valid(k);
    n_checks++;
    if (valid !== 1'b1 || rc !== 8'd5 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_rerun: got valid=%b count=%0d ovf=%b need 1/5/0", valid, rc, ovf);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_idle_abort: got busy=%b need 0", busy);
    end
    gate_len = 0;
    pulse_start();
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || gate !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_settle_abort: got busy=%b gate=%b need 0/0", busy, gate);
    end
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (gate_len != 0) begin
      n_fail++;
      $display("FAIL sim_no_gate: got %0d gate cycles need 0", gate_len);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_abort();
    test_saturation();
    test_async_reset();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
